// File: rtl/pixel_frame_source.sv
// pixel_frame_source
// Reads one IMG_W x IMG_H greyscale frame out of a synchronous single-port
// frame buffer (1-cycle read latency) in raster order. It presents the frame as a
// valid/ready pixel stream tagged with coordinates and frame/line markers.
// A 2-entry output FIFO absorbs the RAM latency. Back-pressure therefore never
// drops or repeats a pixel, and an always-ready sink gets 1 pixel per clock.
//
// Ports
//   clk           system clock
//   reset         asynchronous active-low reset
//   start         one-cycle request to start a frame (ignored while busy)
//   continuous    loop frames back-to-back (sampled at last-address issue)
//   freeze        suspend new RAM reads; buffered pixels keep draining
//   mem_rd_en     RAM read strobe
//   mem_addr      RAM read address
//   mem_rdata     RAM read data, valid the cycle after the read was sampled
//   pix_out       pixel data
//   valid_out     pixel valid
//   output_ready  downstream ready
//   pixel_x/y     coordinates of pix_out
//   sof/eol/eof   start-of-frame / end-of-line / end-of-frame markers
//   busy          frame in progress (STREAM or DRAIN)
//   frame_count   frames fully accepted downstream, wraps at 2^16
module pixel_frame_source #(
    parameter int BITS   = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = $clog2(IMG_W * IMG_H),
    localparam int XW    = $clog2(IMG_W),
    localparam int YW    = $clog2(IMG_H)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              continuous,
    input  logic              freeze,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [BITS-1:0]   mem_rdata,
    output logic [BITS-1:0]   pix_out,
    output logic              valid_out,
    input  logic              output_ready,
    output logic [XW-1:0]     pixel_x,
    output logic [YW-1:0]     pixel_y,
    output logic              sof,
    output logic              eol,
    output logic              eof,
    output logic              busy,
    output logic [15:0]       frame_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    // Pixel attributes known at issue time; they travel alongside the read.
    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          sof;
        logic          eol;
        logic          eof;
    } meta_t;

    typedef struct packed {
        logic [BITS-1:0] data;
        meta_t           meta;
    } beat_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [XW-1:0]     LAST_X    = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     LAST_Y    = YW'(IMG_H - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XW-1:0]     rx_q, rx_d;
    logic [YW-1:0]     ry_q, ry_d;
    logic [1:0]        occ_q, occ_d;
    logic              inflight_q;
    meta_t             meta_q, meta_s;
    beat_t             head_q, head_d;
    beat_t             tail_q, tail_d;
    beat_t             incoming_s;
    logic [15:0]       fc_q, fc_d;
    logic              pop_s;
    logic              push_s;
    logic              rd_en_s;
    logic [2:0]        level_s;

    // Handshake, read-issue decision and issue-time pixel attributes.
    always_comb begin
        pop_s      = 1'b0;
        push_s     = inflight_q;
        level_s    = 3'd0;
        rd_en_s    = 1'b0;
        meta_s     = '0;
        pop_s      = (occ_q != 2'd0) && output_ready;
        // Count pixels that will occupy the FIFO after this edge. A new read is
        // allowed only if that still leaves room for the read's own data.
        level_s    = 3'(occ_q) + 3'(inflight_q) - 3'(pop_s);
        rd_en_s    = (state_q == S_STREAM) && !freeze && (level_s < 3'd2);
        meta_s.x   = rx_q;
        meta_s.y   = ry_q;
        meta_s.sof = (rx_q == '0) && (ry_q == '0);
        meta_s.eol = (rx_q == LAST_X);
        meta_s.eof = (rx_q == LAST_X) && (ry_q == LAST_Y);
        incoming_s = {mem_rdata, meta_q};
    end

    // Frame sequencing FSM: next state and read address/coordinate counters.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_STREAM;
                    addr_d  = '0;
                    rx_d    = '0;
                    ry_d    = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STREAM: begin
                if (rd_en_s) begin
                    if (addr_q == LAST_ADDR) begin
                        // Wrap now so a continuous run has no bubble.
                        addr_d  = '0;
                        rx_d    = '0;
                        ry_d    = '0;
                        state_d = continuous ? S_STREAM : S_DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        if (rx_q == LAST_X) begin
                            rx_d = '0;
                            ry_d = (ry_q == LAST_Y) ? '0 : ry_q + YW'(1);
                        end else begin
                            rx_d = rx_q + XW'(1);
                        end
                    end
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_DRAIN: begin
                if ((occ_q == 2'd0) && !inflight_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output FIFO next state: head_q is always the presented pixel, tail_q the second.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        fc_d   = fc_q;
        case ({push_s, pop_s})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = incoming_s;
                    occ_d  = 2'd1;
                end else if (occ_q == 2'd1) begin
                    tail_d = incoming_s;
                    occ_d  = 2'd2;
                end else begin
                    occ_d = occ_q;
                end
            end
            2'b01: begin
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                end else begin
                    head_d = head_q;
                end
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous push and pop keeps occupancy, including when full.
                if (occ_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = incoming_s;
                end else begin
                    head_d = incoming_s;
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase
        if (pop_s && head_q.meta.eof) begin
            fc_d = fc_q + 16'd1;
        end else begin
            fc_d = fc_q;
        end
    end

    // State, counters and FIFO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rx_q       <= '0;
            ry_q       <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            meta_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            fc_q       <= 16'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rx_q       <= rx_d;
            ry_q       <= ry_d;
            occ_q      <= occ_d;
            inflight_q <= rd_en_s;
            meta_q     <= rd_en_s ? meta_s : meta_q;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fc_q       <= fc_d;
        end
    end

    assign mem_rd_en   = rd_en_s;
    assign mem_addr    = addr_q;
    assign valid_out   = (occ_q != 2'd0);
    assign pix_out     = head_q.data;
    assign pixel_x     = head_q.meta.x;
    assign pixel_y     = head_q.meta.y;
    assign sof         = head_q.meta.sof;
    assign eol         = head_q.meta.eol;
    assign eof         = head_q.meta.eof;
    assign busy        = (state_q != S_IDLE);
    assign frame_count = fc_q;

endmodule

// File: tb/tb_pixel_frame_source.sv
// Bench for pixel_frame_source on a 4x3 frame. RAM[a] = a.
// Each stimulus step pushes its expected beats into a queue. A negedge monitor
// pops one expected beat for each handshake and compares it with the DUT beat.
module tb_pixel_frame_source;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          continuous;
    logic          freeze;
    logic          output_ready;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata;
    logic [7:0]    pix_out;
    logic          valid_out;
    logic [1:0]    pixel_x;
    logic [1:0]    pixel_y;
    logic          sof;
    logic          eol;
    logic          eof;
    logic          busy;
    logic [15:0]   frame_count;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] x;
        logic [1:0] y;
        logic       sof;
        logic       eol;
        logic       eof;
    } beat_t;

    beat_t sb[$];
    beat_t got;
    beat_t held;
    beat_t exp_b;
    bit    hold = 1'b0;
    int    n_cmp = 0;
    int    n_bad = 0;
    int    pop_cnt = 0;

    pixel_frame_source #(.BITS(8), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .reset(reset), .start(start), .continuous(continuous),
        .freeze(freeze), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .pix_out(pix_out), .valid_out(valid_out),
        .output_ready(output_ready), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .sof(sof), .eol(eol), .eof(eof), .busy(busy), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    // Frame buffer model: RAM[a] = a, 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= 8'(mem_addr);
    end

    assign got = {pix_out, pixel_x, pixel_y, sof, eol, eof};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_frame();
        for (int a = 0; a < W * H; a++) begin
            beat_t b;
            b.d   = 8'(a);
            b.x   = 2'(a % W);
            b.y   = 2'(a / W);
            b.sof = (a == 0);
            b.eol = ((a % W) == W - 1);
            b.eof = (a == W * H - 1);
            sb.push_back(b);
        end
    endtask

    // Run until the block is idle and every expected beat is seen, optionally
    // applying the 1,0,0,1 ready pattern.
    task automatic run_until_idle(input bit bp, input string name);
        int  ph;
        bit  done;
        ph   = 0;
        done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bp) begin
                output_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                ph++;
            end
            if (!busy && (sb.size() == 0)) begin
                done = 1'b1;
                break;
            end
            step();
        end
        output_ready = 1'b1;
        check(name, 64'(done), 64'd1);
    endtask

    // Monitor: scoreboard pop on every handshake, hold check on every stall.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (hold) begin
                check("stall_hold", 64'({valid_out, got}), 64'({1'b1, held}));
            end
            if (valid_out && output_ready) begin
                pop_cnt++;
                if (sb.size() == 0) begin
                    check("extra_beat", 64'(got), 64'hFFFF_FFFF);
                end else begin
                    exp_b = sb.pop_front();
                    check("beat", 64'(got), 64'(exp_b));
                end
                hold = 1'b0;
            end else if (valid_out) begin
                hold = 1'b1;
                held = got;
            end else begin
                hold = 1'b0;
            end
        end else begin
            hold = 1'b0;
        end
    end

    initial begin
        int cnt;
        int base;
        bit flag;
        reset        = 1'b0;
        start        = 1'b0;
        continuous   = 1'b0;
        freeze       = 1'b0;
        output_ready = 1'b1;
        repeat (2) step();
        check("reset_vals", 64'({mem_rd_en, mem_addr, valid_out, pix_out, pixel_x, pixel_y,
                                 sof, eol, eof, busy, frame_count}), 64'd0);
        reset = 1'b1;
        step();

        // Mid-run reset: outputs clear at once, the next frame restarts at address 0.
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        reset = 1'b0;
        #1;
        check("midrun_reset", 64'({mem_rd_en, mem_addr, valid_out, pix_out, pixel_x, pixel_y,
                                   sof, eol, eof, busy, frame_count}), 64'd0);
        sb.delete();
        step();
        reset = 1'b1;
        step();

        // Single frame, always ready: latency, throughput, drain, frame count.
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        check("lat_e0", 64'({mem_rd_en, valid_out, busy}), 64'(3'b101));
        step();
        check("lat_e1", 64'(valid_out), 64'd0);
        step();
        cnt = 0;
        for (int i = 0; i < W * H; i++) begin
            cnt += int'(valid_out);
            step();
        end
        check("thruput_1f", 64'(cnt), 64'd12);
        check("sb_empty_1f", 64'(sb.size()), 64'd0);
        check("drain_1f", 64'({busy, valid_out}), 64'(2'b10));
        check("fc_1f", 64'(frame_count), 64'd1);
        step();
        check("idle_1f", 64'(busy), 64'd0);

        // Back-pressure with ready pattern 1,0,0,1.
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        run_until_idle(1'b1, "bp_done");
        check("fc_bp", 64'(frame_count), 64'd2);

        // Freeze for 10 cycles once beat 5 has been accepted.
        push_frame();
        base  = pop_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (pop_cnt >= base + 6) break;
            step();
        end
        check("frz_reach5", 64'(pop_cnt >= base + 6), 64'd1);
        freeze = 1'b1;
        #1;
        base = pop_cnt;
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (mem_rd_en) flag = 1'b1;
            step();
        end
        check("frz_no_read", 64'(flag), 64'd0);
        check("frz_beats_le2", 64'((pop_cnt - base) <= 2), 64'd1);
        freeze = 1'b0;
        run_until_idle(1'b0, "frz_done");
        check("fc_frz", 64'(frame_count), 64'd3);

        // Continuous: three back-to-back frames, continuous cleared in frame 3.
        push_frame();
        push_frame();
        push_frame();
        continuous = 1'b1;
        start      = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        cnt = 0;
        for (int i = 0; i < 3 * W * H; i++) begin
            cnt += int'(valid_out);
            if (i == 28) continuous = 1'b0;
            step();
        end
        check("thruput_3f", 64'(cnt), 64'd36);
        check("sb_empty_3f", 64'(sb.size()), 64'd0);
        check("drain_3f", 64'({busy, valid_out}), 64'(2'b10));
        check("fc_3f", 64'(frame_count), 64'd6);
        step();
        check("idle_3f", 64'(busy), 64'd0);

        // Start pulses while busy are ignored.
        push_frame();
        start = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            start = ((i % 2) == 0);
            step();
        end
        start = 1'b0;
        run_until_idle(1'b0, "restart_done");
        check("fc_restart", 64'(frame_count), 64'd7);
        repeat (5) step();
        check("quiet_after", 64'({valid_out, busy}), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
